// File: rtl/hit_sel_responder.sv
// Hit responder: an accepted hit rise waits cfg_lat+1 cycles, then pulses pending, then sel5.
// Optional macro SEL_OVERLAP_EN: sel5 is also asserted during the pending cycle.
module hit_sel_responder #(
  parameter int LAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hit,
  input  logic [LAT_W-1:0] cfg_lat,
  output logic             pending,
  output logic             sel5,
  output logic             busy,
  output logic             drop,
  output logic [CNT_W-1:0] hit_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PEND, S_SEL} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic             hit_q;
  logic             armed;
  logic [LAT_W-1:0] lat_cnt;
  logic             rise;

  // armed stays low for the first edge after reset, so a hit that is already
  // high when reset releases is never taken as a rise.
  assign rise = hit & ~hit_q & ~pending & armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      hit_q   <= 1'b0;
      armed   <= 1'b0;
      lat_cnt <= '0;
      hit_cnt <= '0;
      pending <= 1'b0;
      sel5    <= 1'b0;
      busy    <= 1'b0;
      drop    <= 1'b0;
    end else begin
      hit_q   <= hit;
      armed   <= 1'b1;
      drop    <= rise && (state != S_IDLE);
      pending <= 1'b0;
      sel5    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rise) begin
            lat_cnt <= cfg_lat;
            if (hit_cnt != CNT_MAX) hit_cnt <= hit_cnt + 1'b1;
            state   <= S_WAIT;
            busy    <= 1'b1;
          end
        end
        S_WAIT: begin
          if (lat_cnt == '0) begin
            state   <= S_PEND;
            pending <= 1'b1;
`ifdef SEL_OVERLAP_EN
            sel5    <= 1'b1;
`else
            sel5    <= 1'b0;
`endif
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        S_PEND: begin
          state <= S_SEL;
          sel5  <= 1'b1;
        end
        S_SEL: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hit_sel_responder.sv
// Bench for hit_sel_responder: directed scenarios plus random traffic against a
// timeline model (acceptance edge + latency gives every output window directly).
module tb_hit_sel_responder;
  localparam int LAT_W = 4;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef SEL_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             hit;
  logic [LAT_W-1:0] cfg_lat;
  logic             pending;
  logic             sel5;
  logic             busy;
  logic             drop;
  logic [CNT_W-1:0] hit_cnt;

  hit_sel_responder #(.LAT_W(LAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .hit(hit), .cfg_lat(cfg_lat),
    .pending(pending), .sel5(sel5), .busy(busy), .drop(drop), .hit_cnt(hit_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: a transaction is fully described by its acceptance edge and latency.
  int cyc = 0;
  int acc = 0;
  int lat = 0;
  bit active = 0;
  bit m_hitq = 0, m_armed = 0, m_pend = 0, m_sel = 0, m_busy = 0, m_drop = 0;
  int m_cnt = 0;
  int pend_seen = 0;
  int sel_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge(input bit r, input bit h, input int l);
    bit rise, in_txn;
    cyc++;
    if (r) begin
      active = 0; m_hitq = 0; m_armed = 0; m_pend = 0; m_sel = 0;
      m_busy = 0; m_drop = 0; m_cnt = 0;
    end else begin
      rise   = h && !m_hitq && !m_pend && m_armed;
      in_txn = active && (cyc - 1) >= acc && (cyc - 1) <= acc + lat + 2;
      m_drop = rise && in_txn;
      if (rise && !in_txn) begin
        acc = cyc; lat = l; active = 1;
        if (m_cnt < CNT_MAX) m_cnt++;
        $display("cycle %0d: accept hit lat=%0d count=%0d", cyc, l, m_cnt);
      end else if (m_drop) begin
        $display("cycle %0d: drop hit", cyc);
      end
      m_hitq  = h;
      m_armed = 1;
      m_busy  = active && cyc >= acc && cyc <= acc + lat + 2;
      m_pend  = active && cyc == acc + lat + 1;
      m_sel   = active && (cyc == acc + lat + 2 || (OVERLAP && cyc == acc + lat + 1));
    end
  endtask

  task automatic step(input bit r, input bit h, input int l);
    rst = r; hit = h; cfg_lat = l[LAT_W-1:0];
    @(posedge clk);
    model_edge(r, h, l);
    #1;
    chk("pending", {31'd0, pending}, {31'd0, m_pend});
    chk("sel5",    {31'd0, sel5},    {31'd0, m_sel});
    chk("busy",    {31'd0, busy},    {31'd0, m_busy});
    chk("drop",    {31'd0, drop},    {31'd0, m_drop});
    chk("hit_cnt", {{(32-CNT_W){1'b0}}, hit_cnt}, m_cnt);
    if (pending === 1'b1) pend_seen++;
    if (sel5 === 1'b1) sel_seen++;
  endtask

  initial begin
    rst = 1'b1; hit = 1'b0; cfg_lat = '0;
    step(1, 0, 0);
    step(1, 0, 0);
    // hit already high as reset releases, then held: never a rise
    step(0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0);
    chk("no_rise_at_reset_release", {{(32-CNT_W){1'b0}}, hit_cnt}, 0);
    step(0, 0, 0);
    // cfg_lat = 0 request
    step(0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    chk("cnt_after_lat0", {{(32-CNT_W){1'b0}}, hit_cnt}, 1);
    // cfg_lat = 3, cfg changed after acceptance, second rise in WAIT dropped
    step(0, 1, 3);
    step(0, 1, 7);
    step(0, 0, 7);
    step(0, 1, 7);
    for (int i = 0; i < 6; i++) step(0, 0, 7);
    chk("cnt_after_drop", {{(32-CNT_W){1'b0}}, hit_cnt}, 2);
    // rise in the SEL cycle is dropped
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    chk("cnt_after_sel_rise", {{(32-CNT_W){1'b0}}, hit_cnt}, 3);
    // reset during PEND aborts the transaction
    step(0, 1, 2);
    for (int i = 0; i < 3; i++) step(0, 0, 2);
    chk("in_pend_before_reset", {31'd0, pending}, 1);
    step(1, 0, 0);
    sel_seen = 0;
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    chk("no_sel_after_abort", sel_seen, 0);
    // random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 299) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 15));
    // saturation
    step(1, 0, 0);
    step(0, 0, 0);
    pend_seen = 0;
    sel_seen  = 0;
    for (int i = 0; i < 280; i++) begin
      step(0, 1, 0);
      for (int j = 0; j < 4; j++) step(0, 0, 0);
    end
    chk("cnt_saturated", {{(32-CNT_W){1'b0}}, hit_cnt}, CNT_MAX);
    chk("pending_pulses", pend_seen, 280);
    chk("sel5_cycles", sel_seen, OVERLAP ? 560 : 280);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
